// File: rtl/apb_slave_bank.sv
// APB2 slave with three register regions (one per psel bit), protocol-violation
// detection and saturating transfer counters.
//
// state  | meaning
// IDLE   | no transfer in flight; waiting for a clean setup phase
// SETUP  | setup captured; expecting a matching enable cycle next
// ACCESS | enable cycle accepted; next edge behaves like IDLE
module apb_slave_bank #(
    parameter int WORDS = 16
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic [2:0]  psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] pr_data,
    input  logic        err_clr,
    output logic        prot_err,
    output logic [15:0] wr_count,
    output logic [15:0] rd_count
);

    localparam int IW = $clog2(WORDS);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t      state_q, state_d;
    logic [2:0]  sel_q, sel_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] pr_data_q, pr_data_d;
    logic        prot_err_q, prot_err_d;
    logic [15:0] wr_count_q, wr_count_d;
    logic [15:0] rd_count_q, rd_count_d;
    logic [31:0] mem_q [0:2][WORDS];
    logic [31:0] mem_d [0:2][WORDS];

    logic          multi_sel;
    logic          one_sel;
    logic          err;
    logic [IW-1:0] idx_in;
    logic [IW-1:0] idx_cap;

    function automatic logic [1:0] region_of(input logic [2:0] s);
        return s[2] ? 2'd2 : (s[1] ? 2'd1 : 2'd0);
    endfunction

    assign multi_sel = (psel & (psel - 3'd1)) != 3'd0;
    assign one_sel   = (psel != 3'd0) && !multi_sel;
    assign idx_in    = paddr[IW+1:2];
    assign idx_cap   = addr_q[IW+1:2];

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        pr_data_d  = pr_data_q;
        wr_count_d = wr_count_q;
        rd_count_d = rd_count_q;
        mem_d      = mem_q;
        err        = 1'b0;

        case (state_q)
            SETUP: begin
                if (penable && psel == sel_q && paddr == addr_q && pwrite == write_q) begin
                    state_d = ACCESS;
                    if (write_q) begin
                        mem_d[region_of(sel_q)][idx_cap] = wdata_q;
                        wr_count_d = (wr_count_q == 16'hFFFF) ? wr_count_q : wr_count_q + 16'd1;
                    end else begin
                        rd_count_d = (rd_count_q == 16'hFFFF) ? rd_count_q : rd_count_q + 16'd1;
                    end
                end else begin
                    err = 1'b1;
                end
            end
            default: begin
                // IDLE and the cycle after ACCESS share the same entry rules
                state_d   = IDLE;
                pr_data_d = 32'h0;
                if (multi_sel || (penable && (psel != 3'd0 || state_q == ACCESS))) begin
                    err = 1'b1;
                end else if (one_sel) begin
                    state_d   = SETUP;
                    sel_d     = psel;
                    addr_d    = paddr;
                    write_d   = pwrite;
                    wdata_d   = pwdata;
                    pr_data_d = pwrite ? 32'h0 : mem_q[region_of(psel)][idx_in];
                end
            end
        endcase

        if (err) begin
            state_d   = IDLE;
            pr_data_d = 32'h0;
        end

        prot_err_d = err ? 1'b1 : (err_clr ? 1'b0 : prot_err_q);
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q    <= IDLE;
            sel_q      <= 3'b000;
            addr_q     <= 32'h0;
            write_q    <= 1'b0;
            wdata_q    <= 32'h0;
            pr_data_q  <= 32'h0;
            prot_err_q <= 1'b0;
            wr_count_q <= 16'h0;
            rd_count_q <= 16'h0;
            for (int r = 0; r < 3; r++) begin
                for (int w = 0; w < WORDS; w++) begin
                    mem_q[r][w] <= 32'h0;
                end
            end
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            pr_data_q  <= pr_data_d;
            prot_err_q <= prot_err_d;
            wr_count_q <= wr_count_d;
            rd_count_q <= rd_count_d;
            mem_q      <= mem_d;
        end
    end

    assign pr_data  = pr_data_q;
    assign prot_err = prot_err_q;
    assign wr_count = wr_count_q;
    assign rd_count = rd_count_q;

endmodule

// File: tb/tb_apb_slave_bank.sv
// Directed bench for apb_slave_bank: vector table of APB transfers plus
// hand-written protocol-error, saturation and reset sequences.
module tb_apb_slave_bank;

    logic        hclk;
    logic        hresetn;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] pr_data;
    logic        err_clr;
    logic        prot_err;
    logic [15:0] wr_count;
    logic [15:0] rd_count;

    int n_checks = 0;
    int n_err    = 0;
    int exp_wr   = 0;
    int exp_rd   = 0;

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [14];

    apb_slave_bank #(.WORDS(16)) dut (
        .hclk     (hclk),
        .hresetn  (hresetn),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .pr_data  (pr_data),
        .err_clr  (err_clr),
        .prot_err (prot_err),
        .wr_count (wr_count),
        .rd_count (rd_count)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_counts(input string name);
        check({name, " wr_count"}, {16'h0, wr_count}, exp_wr);
        check({name, " rd_count"}, {16'h0, rd_count}, exp_rd);
    endtask

    // Full transfer: setup edge, then enable edge. Leaves the bus idle-driven
    // without clocking so a following call runs back-to-back.
    task automatic xfer(input logic [2:0] sel, input logic [31:0] addr, input logic wr,
                        input logic [31:0] wd, output logic [31:0] rd_en, output logic [31:0] rd_acc);
        psel    = sel;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wd;
        tick();
        rd_en   = pr_data;
        penable = 1'b1;
        tick();
        rd_acc  = pr_data;
        if (wr) exp_wr = (exp_wr == 16'hFFFF) ? exp_wr : exp_wr + 1;
        else    exp_rd = (exp_rd == 16'hFFFF) ? exp_rd : exp_rd + 1;
        psel    = 3'b000;
        penable = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [2:0] sel, input logic [31:0] addr,
                              input logic [31:0] exp);
        logic [31:0] a, b;
        xfer(sel, addr, 1'b0, 32'h0, a, b);
        check(name, a, exp);
    endtask

    task automatic err_clear();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    initial begin
        logic [31:0] rd_en, rd_acc;

        vecs[0]  = '{3'b001, 32'h04, 1'b1, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{3'b001, 32'h04, 1'b0, 32'h0,        32'hDEADBEEF};
        vecs[2]  = '{3'b010, 32'h0C, 1'b1, 32'h11111111, 32'h0};
        vecs[3]  = '{3'b100, 32'h0C, 1'b0, 32'h0,        32'h00000000};
        vecs[4]  = '{3'b010, 32'h0C, 1'b0, 32'h0,        32'h11111111};
        vecs[5]  = '{3'b001, 32'h00, 1'b1, 32'hA5A5A5A5, 32'h0};
        vecs[6]  = '{3'b001, 32'h00, 1'b0, 32'h0,        32'hA5A5A5A5};
        vecs[7]  = '{3'b100, 32'h08, 1'b1, 32'hCAFEF00D, 32'h0};
        vecs[8]  = '{3'b100, 32'h48, 1'b0, 32'h0,        32'hCAFEF00D};
        vecs[9]  = '{3'b010, 32'h44, 1'b1, 32'h0BADF00D, 32'h0};
        vecs[10] = '{3'b010, 32'h04, 1'b0, 32'h0,        32'h0BADF00D};
        vecs[11] = '{3'b001, 32'h3C, 1'b0, 32'h0,        32'h00000000};
        vecs[12] = '{3'b001, 32'h7C, 1'b1, 32'h55AA55AA, 32'h0};
        vecs[13] = '{3'b001, 32'h3C, 1'b0, 32'h0,        32'h55AA55AA};

        hresetn = 1'b0;
        psel    = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'h0;
        pwdata  = 32'h0;
        err_clr = 1'b0;
        tick();
        tick();
        check("reset pr_data", pr_data, 32'h0);
        check("reset prot_err", {31'h0, prot_err}, 32'h0);
        check_counts("reset");
        hresetn = 1'b1;
        tick();
        tick();
        check("idle no error", {31'h0, prot_err}, 32'h0);

        // Table: all transfers back-to-back with no idle cycle between them.
        for (int i = 0; i < 14; i++) begin
            xfer(vecs[i].sel, vecs[i].addr, vecs[i].wr, vecs[i].wd, rd_en, rd_acc);
            if (vecs[i].wr) begin
                check($sformatf("vec%0d write pr_data", i), rd_en, 32'h0);
            end else begin
                check($sformatf("vec%0d read enable", i), rd_en, vecs[i].exp);
                check($sformatf("vec%0d read access", i), rd_acc, vecs[i].exp);
            end
            check($sformatf("vec%0d prot_err", i), {31'h0, prot_err}, 32'h0);
            check_counts($sformatf("vec%0d", i));
        end
        tick();
        check("pr_data cleared after access", pr_data, 32'h0);

        // Multi-bit psel: error, nothing captured or written.
        psel = 3'b011; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'hFFFFFFFF;
        tick();
        check("multi psel prot_err", {31'h0, prot_err}, 32'h1);
        psel = 3'b000;
        tick();
        check_counts("multi psel");
        read_check("multi psel no write r0", 3'b001, 32'h10, 32'h0);
        read_check("multi psel no write r1", 3'b010, 32'h10, 32'h0);
        check("prot_err sticky", {31'h0, prot_err}, 32'h1);
        tick();
        err_clear();
        check("err_clr clears", {31'h0, prot_err}, 32'h0);

        // Error coinciding with err_clr: error wins.
        psel = 3'b110; err_clr = 1'b1;
        tick();
        check("error beats err_clr", {31'h0, prot_err}, 32'h1);
        psel = 3'b000;
        tick();
        err_clr = 1'b0;
        check("err_clr alone clears", {31'h0, prot_err}, 32'h0);

        // Setup followed by penable=0.
        psel = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 32'h14; pwdata = 32'h77777777;
        tick();
        tick();
        check("setup no enable prot_err", {31'h0, prot_err}, 32'h1);
        check_counts("setup no enable");
        psel = 3'b000;
        tick();
        err_clear();
        read_check("setup no enable no write", 3'b001, 32'h14, 32'h0);

        // Enable cycle with a different address.
        tick();
        psel = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 32'h18; pwdata = 32'h66666666;
        tick();
        penable = 1'b1; paddr = 32'h1C;
        tick();
        check("addr change prot_err", {31'h0, prot_err}, 32'h1);
        check_counts("addr change");
        psel = 3'b000; penable = 1'b0;
        tick();
        err_clear();
        read_check("addr change no write a", 3'b001, 32'h18, 32'h0);
        read_check("addr change no write b", 3'b001, 32'h1C, 32'h0);

        // penable held high in the cycle after ACCESS.
        xfer(3'b001, 32'h20, 1'b1, 32'h00000001, rd_en, rd_acc);
        psel = 3'b001; penable = 1'b1;
        tick();
        check("penable after access prot_err", {31'h0, prot_err}, 32'h1);
        check_counts("penable after access");
        psel = 3'b000; penable = 1'b0;
        tick();
        err_clear();

        // penable high in IDLE with a selected region.
        psel = 3'b100; penable = 1'b1; pwrite = 1'b1; paddr = 32'h24; pwdata = 32'h99999999;
        tick();
        check("penable in idle prot_err", {31'h0, prot_err}, 32'h1);
        psel = 3'b000; penable = 1'b0;
        tick();
        err_clear();
        read_check("penable in idle no write", 3'b100, 32'h24, 32'h0);
        check_counts("penable in idle");

        // Saturation: jump the counter close to the top instead of 65535 transfers.
        tick();
        force dut.wr_count_d = 16'hFFFE;
        tick();
        release dut.wr_count_d;
        exp_wr = 16'hFFFE;
        check_counts("sat preload");
        xfer(3'b010, 32'h28, 1'b1, 32'h1, rd_en, rd_acc);
        check("sat reach top", {16'h0, wr_count}, 32'h0000FFFF);
        xfer(3'b010, 32'h28, 1'b1, 32'h2, rd_en, rd_acc);
        check("sat hold top", {16'h0, wr_count}, 32'h0000FFFF);
        check_counts("sat");

        // Reset in the ACCESS-entry cycle of a write, with prot_err set.
        xfer(3'b001, 32'h08, 1'b1, 32'hFFFF0000, rd_en, rd_acc);
        tick();
        psel = 3'b011;
        tick();
        psel = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h12345678;
        tick();
        penable = 1'b1; hresetn = 1'b0;
        tick();
        exp_wr = 0;
        exp_rd = 0;
        check("mid reset pr_data", pr_data, 32'h0);
        check("mid reset prot_err", {31'h0, prot_err}, 32'h0);
        check_counts("mid reset");
        hresetn = 1'b1; psel = 3'b000; penable = 1'b0;
        tick();
        read_check("mid reset idx2", 3'b001, 32'h08, 32'h0);
        read_check("mid reset idx1", 3'b001, 32'h04, 32'h0);
        check_counts("after reset reads");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
